nukv_value_stream_arbiter: RTL and testbench

- Shares one segmented value datapath (512-bit beats toward the value segmenter/memory write path) between NUM_PORTS value producers.
- Each producer presents a multi-beat value whose first beat carries the value length in 8-byte words in bits [15:0].
- Arbitration is round-robin at value granularity: a grant holds until the final beat of the value is forwarded.
- Output is a registered valid/ready stream with last and source id.

---
 rtl/nukv_value_stream_arbiter.sv | 153 +++++++++++++++
 tb/tb_nukv_value_stream_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nukv_value_stream_arbiter.sv
// nukv_value_stream_arbiter
// Round-robin arbiter that shares one registered 512-bit value stream between
// NUM_PORTS producers. A grant covers a whole value: the first beat carries the
// value length in 8-byte words in bits [15:0], which sets the beat count.
// Optional build macro: NUKV_VARB_STATS_EN adds per-port completed-value
// counters on the stat_values port.
module nukv_value_stream_arbiter #(
    parameter int MEMORY_WIDTH = 512,
    parameter int NUM_PORTS    = 2,
    parameter int SRC_W        = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS*MEMORY_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]              in_valid,
    output logic [NUM_PORTS-1:0]              in_ready,
    output logic [MEMORY_WIDTH-1:0]           output_data,
    output logic                              output_valid,
    output logic                              output_last,
    output logic [SRC_W-1:0]                  output_src,
    input  logic                              output_ready
`ifdef NUKV_VARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]           stat_values
`endif
);

    // Per-port views are padded to a power of two so a SRC_W-bit index is
    // always in range; padding slots never request.
    localparam int NUM_SLOTS = 1 << SRC_W;

    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    state_t                  state_reg;
    logic [SRC_W-1:0]        grant_reg;
    logic [SRC_W-1:0]        last_grant_reg;
    logic [13:0]             beats_left_reg;

    logic [MEMORY_WIDTH-1:0] slot_data [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    slot_valid;
    logic                    out_free;
    logic                    accept;
    logic                    pick_found;
    logic [SRC_W-1:0]        pick;
    logic [15:0]             hdr_len;
    logic [13:0]             hdr_beats;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi < NUM_PORTS) begin : g_port
                assign slot_data[gi]  = in_data[gi*MEMORY_WIDTH +: MEMORY_WIDTH];
                assign slot_valid[gi] = in_valid[gi];
            end else begin : g_pad
                assign slot_data[gi]  = '0;
                assign slot_valid[gi] = 1'b0;
            end
        end
    endgenerate

    // The output register can take a new beat when empty or being drained.
    assign out_free = !output_valid || output_ready;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign in_ready[gi] = (state_reg == ST_BURST) && (grant_reg == SRC_W'(gi)) && out_free;
        end
    endgenerate

    assign accept = (state_reg == ST_BURST) && slot_valid[grant_reg] && out_free;

    // Header decode of the candidate port: words -> 64-byte beats, rounded up,
    // zero length still moves the header beat. Max result 8192 fits 14 bits.
    assign hdr_len   = slot_data[pick][15:0];
    assign hdr_beats = (hdr_len == 16'd0) ? 14'd1 : 14'(({1'b0, hdr_len} + 17'd7) >> 3);

    // Round-robin pick: first requesting port after the last one served.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!pick_found && slot_valid[SRC_W'((int'(last_grant_reg) + k) % NUM_PORTS)]) begin
                pick_found = 1'b1;
                pick       = SRC_W'((int'(last_grant_reg) + k) % NUM_PORTS);
            end
        end
    end

    // Arbitration FSM and registered output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= SRC_W'(NUM_PORTS - 1);
            beats_left_reg <= '0;
            output_data    <= '0;
            output_valid   <= 1'b0;
            output_last    <= 1'b0;
            output_src     <= '0;
        end else begin
            if (accept) begin
                output_data  <= slot_data[grant_reg];
                output_valid <= 1'b1;
                output_src   <= grant_reg;
                output_last  <= (beats_left_reg == 14'd1);
            end else if (output_valid && output_ready) begin
                output_valid <= 1'b0;
                output_last  <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_reg      <= pick;
                        beats_left_reg <= hdr_beats;
                        state_reg      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        beats_left_reg <= beats_left_reg - 14'd1;
                        if (beats_left_reg == 14'd1) begin
                            last_grant_reg <= grant_reg;
                            state_reg      <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef NUKV_VARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stat
            logic [31:0] stat_count_reg;
            // Count completed values per port, saturating at all-ones.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    stat_count_reg <= '0;
                end else if (accept && (beats_left_reg == 14'd1) && (grant_reg == SRC_W'(gi))
                             && (stat_count_reg != 32'hFFFF_FFFF)) begin
                    stat_count_reg <= stat_count_reg + 32'd1;
                end
            end
            assign stat_values[gi*32 +: 32] = stat_count_reg;
        end
    endgenerate
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_nukv_value_stream_arbiter.sv
// tb_nukv_value_stream_arbiter
// Drives value producers from per-port beat tables and checks the merged
// stream against a round-robin, value-granular reference model.
module tb_nukv_value_stream_arbiter;

    localparam int MW = 512;
    localparam int NP = 2;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP*MW-1:0]  in_data = '0;
    logic [NP-1:0]     in_valid = '0;
    logic [NP-1:0]     in_ready;
    logic [MW-1:0]     output_data;
    logic              output_valid;
    logic              output_last;
    logic [SW-1:0]     output_src;
    logic              output_ready = 1'b0;
`ifdef NUKV_VARB_STATS_EN
    logic [NP*32-1:0]  stat_values;
`endif

    always #5 clk = ~clk;

    nukv_value_stream_arbiter #(.MEMORY_WIDTH(MW), .NUM_PORTS(NP), .SRC_W(SW)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .output_data(output_data),
        .output_valid(output_valid),
        .output_last(output_last),
        .output_src(output_src),
        .output_ready(output_ready)
`ifdef NUKV_VARB_STATS_EN
        ,
        .stat_values(stat_values)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [MW-1:0] beat_mem [NP][64];
    bit            last_mem [NP][64];
    bit            hdr_mem  [NP][64];
    int            nbeats   [NP];
    int            nvals    [NP];
    int            wr_ptr   [NP];
    int            rd_ptr   [NP];
    int            tot_vals [NP];
    int            src_seq [$];
    int            model_last = NP - 1;
    int            cur_src;
    bit            in_value;
    int            ready_mode;
    bit            rand_gaps;
    int            gap_at = -1;
    int            gap_left;
    int            cyc = 0;
    int            first_in;
    int            first_out;
    int            out_beats;
    bit            held_pending;
    logic [MW-1:0] held_data;

    function automatic logic [MW-1:0] rand_beat();
        logic [MW-1:0] d;
        for (int w = 0; w < MW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic new_phase();
        for (int p = 0; p < NP; p++) begin
            nbeats[p] = 0; nvals[p] = 0; wr_ptr[p] = 0; rd_ptr[p] = 0;
        end
        src_seq.delete();
        in_value = 0; first_in = -1; first_out = -1; out_beats = 0;
        gap_at = -1; gap_left = 0; rand_gaps = 0; ready_mode = 0;
    endtask

    task automatic add_value(input int p, input int len);
        int nb;
        logic [MW-1:0] d;
        nb = (len == 0) ? 1 : (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = rand_beat();
            if (b == 0) d[15:0] = len[15:0];
            beat_mem[p][nbeats[p]] = d;
            hdr_mem[p][nbeats[p]]  = (b == 0);
            last_mem[p][nbeats[p]] = (b == nb - 1);
            nbeats[p]++;
        end
        nvals[p]++;
    endtask

    // Round-robin over ports that still have values queued.
    task automatic plan_order();
        int rem [NP];
        int left;
        int idx;
        left = 0;
        for (int p = 0; p < NP; p++) begin rem[p] = nvals[p]; left += nvals[p]; end
        while (left > 0) begin
            for (int k = 1; k <= NP; k++) begin
                idx = (model_last + k) % NP;
                if (rem[idx] > 0) break;
            end
            src_seq.push_back(idx);
            rem[idx]--; left--;
            model_last = idx;
        end
    endtask

    task automatic step();
        logic [MW-1:0] d;
        bit v;
        int es;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0: output_ready = 1'b1;
            1: output_ready = (cyc % 2 == 0);
            default: output_ready = ($urandom_range(0, 3) != 0);
        endcase
        for (int p = 0; p < NP; p++) begin
            v = 0;
            d = rand_beat();
            if (wr_ptr[p] < nbeats[p]) begin
                d = beat_mem[p][wr_ptr[p]];
                v = 1;
                if (!hdr_mem[p][wr_ptr[p]]) begin
                    if (rand_gaps && $urandom_range(0, 3) == 0) v = 0;
                    if (p == 0 && wr_ptr[0] == gap_at && gap_left > 0) begin
                        v = 0;
                        gap_left--;
                    end
                end
            end
            if (v && first_in < 0) first_in = cyc;
            in_data[p*MW +: MW] = d;
            in_valid[p] = v;
        end
        #1;
        if (output_valid && first_out < 0) first_out = cyc;
        if (held_pending) begin
            check_val("stall_valid", output_valid, 1);
            check_val("stall_data", output_data, held_data);
        end
        if (output_valid && output_ready) begin
            if (!in_value && src_seq.size() == 0) begin
                check_val("extra_beat", 1, 0);
            end else begin
                if (!in_value) cur_src = src_seq.pop_front();
                es = cur_src;
                check_val("src", output_src, es);
                check_val("data", output_data, beat_mem[es][rd_ptr[es]]);
                check_val("last", output_last, last_mem[es][rd_ptr[es]]);
                in_value = !last_mem[es][rd_ptr[es]];
                rd_ptr[es]++;
                out_beats++;
                $display("beat %0d: src=%0d last=%0b hdr=%0h", out_beats, output_src, output_last, output_data[15:0]);
            end
        end
        held_pending = output_valid && !output_ready;
        held_data = output_data;
        for (int p = 0; p < NP; p++)
            if (in_valid[p] && in_ready[p]) wr_ptr[p]++;
    endtask

    task automatic run_phase(input int abort_beats);
        int budget;
        bit done;
        budget = 0;
        done = 0;
        plan_order();
        while (!done) begin
            step();
            budget++;
            if (abort_beats > 0 && out_beats >= abort_beats) return;
            done = (src_seq.size() == 0) && !in_value;
            for (int p = 0; p < NP; p++) if (rd_ptr[p] != nbeats[p]) done = 0;
            if (!done && budget > 3000) begin
                check_val("timeout", 0, 1);
                return;
            end
        end
        repeat (3) step();
        for (int p = 0; p < NP; p++) tot_vals[p] += nvals[p];
`ifdef NUKV_VARB_STATS_EN
        for (int p = 0; p < NP; p++) check_val("stat_count", stat_values[p*32 +: 32], 32'(tot_vals[p]));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = '0;
        output_ready = 1'b1;
        @(negedge clk);
        #1;
        check_val("rst_valid", output_valid, 0);
        check_val("rst_last", output_last, 0);
        check_val("rst_src", output_src, 0);
        check_val("rst_data", output_data, 0);
        check_val("rst_in_ready", in_ready, 0);
`ifdef NUKV_VARB_STATS_EN
        check_val("rst_stats", stat_values, 0);
`endif
        rst = 1'b1;
        model_last = NP - 1;
        held_pending = 0;
        for (int p = 0; p < NP; p++) tot_vals[p] = 0;
    endtask

    initial begin
        do_reset();

        // Single 3-beat value with latency check
        new_phase();
        add_value(0, 20);
        run_phase(0);
        check_val("latency", 32'(first_out - first_in), 2);

        // Short values on port 1, one beat each
        new_phase();
        add_value(1, 0);
        add_value(1, 8);
        run_phase(0);

        // Both ports continuously offering: alternating grants
        new_phase();
        for (int i = 0; i < 3; i++) begin add_value(0, 16); add_value(1, 16); end
        run_phase(0);

        // Sink toggling ready during a 5-beat value
        new_phase();
        ready_mode = 1;
        add_value(0, 40);
        run_phase(0);

        // Port 0 stalls mid-value while port 1 waits
        do_reset();
        new_phase();
        add_value(0, 32);
        add_value(1, 8);
        gap_at = 2;
        gap_left = 4;
        run_phase(0);

        // Reset during a 4-beat value, then fresh priority
        do_reset();
        new_phase();
        add_value(0, 32);
        run_phase(2);
        do_reset();
        new_phase();
        add_value(1, 8);
        add_value(0, 24);
        run_phase(0);

        // Randomized rounds: random lengths, source gaps, sink back-pressure
        for (int r = 0; r < 4; r++) begin
            new_phase();
            ready_mode = 2;
            rand_gaps = 1;
            for (int p = 0; p < NP; p++) begin
                int nv;
                nv = $urandom_range(1, 5);
                for (int i = 0; i < nv; i++) add_value(p, $urandom_range(0, 64));
            end
            run_phase(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
